debug_uart_rx_fifo: RTL and testbench



---
 rtl/debug_uart_rx_fifo.sv | 245 ++++++++++++++++++++++++
 tb/tb_debug_uart_rx_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : debug_uart_rx_fifo
// Purpose  : Receive half of the debug UART. Deserialises 8N1 frames at a
//            fixed bit rate from an asynchronous pin and queues good bytes in
//            a small circular FIFO that the CPU drains with a read strobe.
//            Framing and overrun errors are kept as sticky flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      core clock, all logic on rising edge
//   rst_n      in   1      synchronous active-low reset
//   uart_rxd   in   1      asynchronous serial input, idle high
//   rd_en      in   1      pop strobe, one cycle per byte (ignored if empty)
//   clr_err    in   1      one-cycle strobe clearing frame_err and overrun
//   rd_data    out  8      byte at FIFO head (valid while rx_valid)
//   rx_valid   out  1      FIFO not empty; also used as the interrupt line
//   rx_count   out  PW+1   number of bytes held, 0..FIFO_DEPTH
//   frame_err  out  1      sticky: a stop bit was sampled low
//   overrun    out  1      sticky: a good byte was dropped on a full FIFO
// ============================================================================
module debug_uart_rx_fifo #(
  parameter int CLK_HZ     = 64_000_000,
  parameter int BIT_RATE   = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             uart_rxd,
  input  logic                             rd_en,
  input  logic                             clr_err,
  output logic [7:0]                       rd_data,
  output logic                             rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]      rx_count,
  output logic                             frame_err,
  output logic                             overrun
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int CPB  = CLK_HZ / BIT_RATE;      // clocks per bit
  localparam int HALF = CPB / 2;                // clocks to mid start bit
  localparam int CW   = $clog2(CPB);            // bit-timer width
  localparam int PW   = $clog2(FIFO_DEPTH);     // FIFO address width

  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CPB - 1);
  localparam logic [PW:0]   FULL_COUNT   = (PW + 1)'(FIFO_DEPTH);

  // Reject parameter sets the timing and pointer arithmetic cannot support.
  generate
    if (CPB < 4) begin : g_cpb_check
      $error("debug_uart_rx_fifo: CLK_HZ/BIT_RATE must be at least 4");
    end
    if ((FIFO_DEPTH < 2) || ((1 << PW) != FIFO_DEPTH)) begin : g_depth_check
      $error("debug_uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Input synchroniser. Both stages reset high so that reset itself never
  // looks like a start bit.
  // --------------------------------------------------------------------------
  logic sync_meta;
  logic rxs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      sync_meta <= uart_rxd;
      rxs       <= sync_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,   // line must be seen high before any frame is accepted
    IDLE      = 3'd1,   // waiting for a falling edge
    START     = 3'd2,   // timing to the middle of the start bit
    DATA      = 3'd3,   // sampling eight data bits, LSB first
    STOP      = 3'd4    // sampling the stop bit
  } state_t;

  state_t         state;
  logic [CW-1:0]  bit_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  // The stop-bit sample instant decides between delivering and rejecting
  // the byte; both decisions act in that same cycle.
  logic stop_sample;
  logic push;
  logic ferr_set;

  assign stop_sample = (state == STOP) && (bit_cnt == CNT_BIT_END);
  assign push        = stop_sample &&  rxs;
  assign ferr_set    = stop_sample && !rxs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= WAIT_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        WAIT_IDLE: begin
          // A line held low (break, or low out of reset) is ignored until
          // it returns to the idle level.
          if (rxs) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (!rxs) begin
            state   <= START;
            bit_cnt <= '0;
          end
        end

        START: begin
          if (bit_cnt == CNT_HALF_END) begin
            if (!rxs) begin
              // Still low at mid start bit: genuine frame. From here every
              // sample lands one full bit period later, i.e. mid-bit.
              state   <= DATA;
              bit_cnt <= '0;
              bit_idx <= '0;
            end else begin
              state <= IDLE;   // short low pulse, treat as noise
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_cnt == CNT_BIT_END) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_cnt == CNT_BIT_END) begin
            bit_cnt <= '0;
            // A low stop bit may be the start of a break, so wait for the
            // line to go idle again before hunting for the next frame.
            state   <= rxs ? IDLE : WAIT_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          state <= WAIT_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO. Pointers carry one extra bit so full and empty are distinguishable
  // and the occupancy is simply their difference.
  // --------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW:0] wptr;
  logic [PW:0] rptr;
  logic [PW:0] count;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        drop;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == FULL_COUNT);
  assign pop     = rd_en && !empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: nothing is visible until a write has occurred.
  always_ff @(posedge clk) begin
    if (push_ok && rst_n) begin
      mem[wptr[PW-1:0]] <= shreg;
    end
  end

  assign rd_data  = mem[rptr[PW-1:0]];
  assign rx_valid = !empty;
  assign rx_count = count;

  // --------------------------------------------------------------------------
  // Sticky error flags. A set event in the same cycle as clr_err wins so no
  // error can slip past the CPU unseen.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_uart_rx_fifo
// Purpose  : Self-checking bench for debug_uart_rx_fifo. Frames are driven
//            bit by bit on the serial pin; a byte-queue model of the receiver
//            predicts FIFO contents and the sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_uart_rx_fifo;

  localparam int CLK_HZ   = 1_600_000;
  localparam int BIT_RATE = 100_000;
  localparam int DEPTH    = 4;
  localparam int CPB      = 16;
  // Push happens HALF + 9*CPB cycles after the receiver sees the start edge,
  // which itself lags the pin by two synchroniser stages.
  localparam int PUSH_K   = 2 + 8 + 9 * CPB;   // 154: edges from pin fall

  logic       clk;
  logic       rst_n;
  logic       uart_rxd;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       frame_err;
  logic       overrun;

  debug_uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BIT_RATE   (BIT_RATE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rxd  (uart_rxd),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .rx_valid  (rx_valid),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Free-running edge counter and rx_valid rise detector for latency check.
  int   cyc      = 0;
  int   rise_cyc = -1;
  bit   arm      = 0;
  logic prev_v   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (arm && rise_cyc < 0 && rx_valid === 1'b1 && prev_v !== 1'b1)
      rise_cyc = cyc;
    prev_v = rx_valid;
  end

  // Reference model: byte queue plus sticky flags.
  logic [7:0] q[$];
  bit         m_fe;
  bit         m_ovr;
  logic [7:0] popped;

  typedef struct {
    logic [7:0] data;
    bit         pop_push;
    bit         clr_before;
    int         pops_after;
    int         exp_count;
    bit         exp_ovr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one 8N1 frame starting at the current negedge. If pop_push is
  // set, rd_en is raised for exactly the push cycle and the head byte seen
  // just before it is returned.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit pop_push,
                            output logic [7:0] head_at_push);
    int k;
    head_at_push = 8'h00;
    for (int b = 0; b < 10; b++) begin
      uart_rxd = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        k = b * CPB + c + 1;
        if (pop_push && k == PUSH_K) begin
          head_at_push = rd_data;
          rd_en = 1'b1;
        end else begin
          rd_en = 1'b0;
        end
      end
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop, input bit pop_push,
                             input logic [7:0] head_at_push);
    if (pop_push && q.size() > 0)
      chk("pop_at_push_data", 32'(head_at_push), 32'(q.pop_front()));
    if (!stop)
      m_fe = 1;
    else if (q.size() < DEPTH)
      q.push_back(d);
    else
      m_ovr = 1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"},     32'(rx_count),  32'(q.size()));
    chk({tag, "_valid"},     32'(rx_valid),  32'(q.size() > 0));
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(m_fe));
    chk({tag, "_overrun"},   32'(overrun),   32'(m_ovr));
    if (q.size() > 0)
      chk({tag, "_head"}, 32'(rd_data), 32'(q[0]));
  endtask

  task automatic pop_one();
    if (q.size() > 0)
      chk("pop_data", 32'(rd_data), 32'(q[0]));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() > 0)
      void'(q.pop_front());
    chk("pop_count", 32'(rx_count), 32'(q.size()));
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_fe  = 0;
    m_ovr = 0;
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0;
    logic [7:0] d;
    logic       stop;
    bit         pp;
    int         npop;

    // Frame-sequence table: exp_count/exp_ovr are hand-derived.
    tbl[0] = '{8'h01, 0, 0, 0, 1, 0};
    tbl[1] = '{8'h80, 0, 0, 0, 2, 0};
    tbl[2] = '{8'hFF, 0, 0, 0, 3, 0};
    tbl[3] = '{8'h00, 0, 0, 4, 4, 0};
    tbl[4] = '{8'h11, 0, 0, 0, 1, 0};
    tbl[5] = '{8'h22, 0, 0, 0, 2, 0};
    tbl[6] = '{8'h33, 0, 0, 0, 3, 0};
    tbl[7] = '{8'h44, 0, 0, 0, 4, 0};
    tbl[8] = '{8'h3C, 0, 0, 0, 4, 1};   // full, no pop: dropped
    tbl[9] = '{8'h3C, 1, 1, 4, 4, 0};   // full, pop in push cycle: accepted

    rst_n = 1'b0; uart_rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    m_fe = 0; m_ovr = 0;
    repeat (3) @(negedge clk);
    chk("reset_count",     32'(rx_count),  32'd0);
    chk("reset_valid",     32'(rx_valid),  32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_overrun",   32'(overrun),   32'd0);
    rst_n = 1'b1;
    idle(5);

    // Single byte with latency measurement.
    arm = 1;
    c0  = cyc;
    send_frame(8'hA5, 1'b1, 0, popped);
    model_frame(8'hA5, 1'b1, 0, popped);
    chk("a5_latency", 32'(rise_cyc - c0), 32'(2 + 8 + 144 + 1));
    chk("a5_data",  32'(rd_data),  32'hA5);
    chk("a5_count", 32'(rx_count), 32'd1);
    pop_one();
    chk("a5_valid_after_pop", 32'(rx_valid), 32'd0);

    // Table-driven back-to-back frames, fill, overrun, pop-at-push.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].clr_before) pulse_clr();
      send_frame(tbl[i].data, 1'b1, tbl[i].pop_push, popped);
      model_frame(tbl[i].data, 1'b1, tbl[i].pop_push, popped);
      chk($sformatf("tbl%0d_count", i), 32'(rx_count), 32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_ovr", i),   32'(overrun),  32'(tbl[i].exp_ovr));
      chk($sformatf("tbl%0d_fe", i),    32'(frame_err), 32'd0);
      if (q.size() > 0)
        chk($sformatf("tbl%0d_head", i), 32'(rd_data), 32'(q[0]));
      for (int p = 0; p < tbl[i].pops_after; p++) pop_one();
    end
    pop_one();   // pop on empty FIFO must not underflow
    check_state("empty_pop");

    // Bad stop bit followed by a long break.
    send_frame(8'h55, 1'b0, 0, popped);
    model_frame(8'h55, 1'b0, 0, popped);
    repeat (40 * CPB) @(negedge clk);
    chk("break_frame_err", 32'(frame_err), 32'd1);
    chk("break_count",     32'(rx_count),  32'd0);
    idle(2 * CPB);
    send_frame(8'h42, 1'b1, 0, popped);
    model_frame(8'h42, 1'b1, 0, popped);
    check_state("after_break");
    pulse_clr();
    chk("clr_frame_err", 32'(frame_err), 32'd0);
    pop_one();

    // Short glitch on idle line.
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    chk("glitch_count", 32'(rx_count),  32'd0);
    chk("glitch_fe",    32'(frame_err), 32'd0);
    send_frame(8'h5A, 1'b1, 0, popped);
    model_frame(8'h5A, 1'b1, 0, popped);
    check_state("after_glitch");
    pop_one();

    // Reset mid-frame with bytes queued and a flag set.
    send_frame(8'h11, 1'b0, 0, popped);
    model_frame(8'h11, 1'b0, 0, popped);
    idle(CPB);
    send_frame(8'hA1, 1'b1, 0, popped);
    model_frame(8'hA1, 1'b1, 0, popped);
    send_frame(8'hB2, 1'b1, 0, popped);
    model_frame(8'hB2, 1'b1, 0, popped);
    check_state("pre_reset");
    uart_rxd = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_count", 32'(rx_count),  32'd0);
    chk("midrst_valid", 32'(rx_valid),  32'd0);
    chk("midrst_fe",    32'(frame_err), 32'd0);
    chk("midrst_ovr",   32'(overrun),   32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    repeat (30 * CPB) @(negedge clk);
    chk("low_after_rst_count", 32'(rx_count), 32'd0);
    pulse_clr();
    idle(2 * CPB);
    send_frame(8'hC3, 1'b1, 0, popped);
    model_frame(8'hC3, 1'b1, 0, popped);
    check_state("after_reset");
    pop_one();

    // Randomised frames, gaps, pops and error clears against the model.
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      pp   = stop && ($urandom_range(0, 3) == 0);
      send_frame(d, stop, pp, popped);
      model_frame(d, stop, pp, popped);
      if (!stop) idle(2 * CPB);
      else       idle($urandom_range(0, CPB));
      check_state($sformatf("rnd%0d", i));
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) pop_one();
      if ($urandom_range(0, 5) == 0) pulse_clr();
    end
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
